// File: rtl/sdram_arb_pkg.sv
// Shared constants and state encoding for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 24;
  localparam int BANK_W       = 2;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE     = 2'd0;
  localparam state_t S_WR_BURST = 2'd1;
  localparam state_t S_RD_BURST = 2'd2;

endpackage

// File: rtl/burst_addr_gen.sv
// Per-side burst offset counter with frame wrap and frame_done pulse.
module burst_addr_gen #(
  parameter int OFF_W     = 22,
  parameter int STEP      = 512,
  parameter int FRAME_LEN = 384000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [OFF_W-1:0] offset,
  output logic             wrap,
  output logic             frame_done
);

  localparam logic [OFF_W:0] STEP_V = (OFF_W+1)'(STEP);
  localparam logic [OFF_W:0] LEN_V  = (OFF_W+1)'(FRAME_LEN);

  logic [OFF_W:0] nxt;

  assign nxt  = {1'b0, offset} + STEP_V;
  assign wrap = adv && (nxt == LEN_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (adv)
        offset <= wrap ? '0 : nxt[OFF_W-1:0];
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Write/read burst scheduler in front of the SDRAM controller.
// Ping-pong frame buffers enabled by defining SDRAM_PINGPANG_EN.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = SDRAM_ADDR_W,
  parameter int FIFO_W    = 10,
  parameter int FRAME_LEN = 384000,
  parameter int WR_BURST  = 512,
  parameter int RD_BURST  = 512,
  parameter int RD_URGENT = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic              read_valid,
  input  logic [FIFO_W-1:0] wr_fifo_usedw,
  input  logic [FIFO_W-1:0] rd_fifo_usedw,
  input  logic              wr_ack,
  input  logic              rd_ack,
  input  logic              wr_end,
  input  logic              rd_end,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic              wr_frame_done,
  output logic              rd_frame_done
);

  localparam int OFF_W = ADDR_W - BANK_W;
  localparam int CW    = FIFO_W + 1;

  localparam logic [CW-1:0] WR_TH  = CW'(WR_BURST);
  localparam logic [CW-1:0] RD_TH  = CW'(RD_BURST);
  localparam logic [CW-1:0] URG_TH = CW'(RD_URGENT);

  if ((FRAME_LEN % WR_BURST) != 0 || (FRAME_LEN % RD_BURST) != 0) begin : g_len_chk
    $error("FRAME_LEN must be a multiple of both burst lengths");
  end

  state_t           state;
  logic             wr_pend, rd_pend, rd_urg;
  logic             wr_adv, rd_adv;
  logic             wr_wrap, rd_wrap;
  logic [OFF_W-1:0] wr_off, rd_off;
  logic             wr_buf, rd_buf;

  assign wr_pend = init_end && ({1'b0, wr_fifo_usedw} >= WR_TH);
  assign rd_pend = init_end && read_valid && ({1'b0, rd_fifo_usedw} < RD_TH);
  assign rd_urg  = {1'b0, rd_fifo_usedw} < URG_TH;

  assign wr_adv = (state == S_WR_BURST) && wr_end;
  assign rd_adv = (state == S_RD_BURST) && rd_end;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      sdram_wr_req <= 1'b0;
      sdram_rd_req <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rd_pend && rd_urg) begin
            state        <= S_RD_BURST;
            sdram_rd_req <= 1'b1;
          end else if (wr_pend) begin
            state        <= S_WR_BURST;
            sdram_wr_req <= 1'b1;
          end else if (rd_pend) begin
            state        <= S_RD_BURST;
            sdram_rd_req <= 1'b1;
          end
        end
        S_WR_BURST: begin
          if (wr_ack || wr_end)
            sdram_wr_req <= 1'b0;
          if (wr_end)
            state <= S_IDLE;
        end
        S_RD_BURST: begin
          if (rd_ack || rd_end)
            sdram_rd_req <= 1'b0;
          if (rd_end)
            state <= S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          sdram_wr_req <= 1'b0;
          sdram_rd_req <= 1'b0;
        end
      endcase
    end
  end

  burst_addr_gen #(
    .OFF_W(OFF_W), .STEP(WR_BURST), .FRAME_LEN(FRAME_LEN)
  ) u_wr_gen (
    .clk(sys_clk), .rst(sys_rst), .adv(wr_adv),
    .offset(wr_off), .wrap(wr_wrap), .frame_done(wr_frame_done)
  );

  burst_addr_gen #(
    .OFF_W(OFF_W), .STEP(RD_BURST), .FRAME_LEN(FRAME_LEN)
  ) u_rd_gen (
    .clk(sys_clk), .rst(sys_rst), .adv(rd_adv),
    .offset(rd_off), .wrap(rd_wrap), .frame_done(rd_frame_done)
  );

`ifdef SDRAM_PINGPANG_EN
  // Reader follows the most recently completed write frame (post-toggle).
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_buf <= 1'b0;
      rd_buf <= 1'b1;
    end else begin
      wr_buf <= wr_buf ^ wr_wrap;
      if (rd_wrap)
        rd_buf <= ~(wr_buf ^ wr_wrap);
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wr_wrap ^ rd_wrap;
  assign wr_buf = 1'b0;
  assign rd_buf = 1'b0;
`endif

  assign sdram_wr_addr = {1'b0, wr_buf, wr_off};
  assign sdram_rd_addr = {1'b0, rd_buf, rd_off};

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed testbench for sdram_port_arb (default and ping-pong builds).
module tb_sdram_port_arb;

`ifdef SDRAM_PINGPANG_EN
  localparam logic [23:0] RD_BASE = 24'h400000;
  localparam logic [23:0] WR_WRAP = 24'h400000;
`else
  localparam logic [23:0] RD_BASE = 24'h000000;
  localparam logic [23:0] WR_WRAP = 24'h000000;
`endif

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        init_end, read_valid;
  logic [9:0]  wr_fifo_usedw, rd_fifo_usedw;
  logic        wr_ack, rd_ack, wr_end, rd_end;
  logic        sdram_wr_req, sdram_rd_req;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic        wr_frame_done, rd_frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arb dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .init_end(init_end), .read_valid(read_valid),
    .wr_fifo_usedw(wr_fifo_usedw), .rd_fifo_usedw(rd_fifo_usedw),
    .wr_ack(wr_ack), .rd_ack(rd_ack),
    .wr_end(wr_end), .rd_end(rd_end),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done)
  );

  task automatic quiet;
    init_end = 0; read_valid = 0;
    wr_fifo_usedw = 0; rd_fifo_usedw = 0;
    wr_ack = 0; rd_ack = 0; wr_end = 0; rd_end = 0;
  endtask

  task automatic do_reset;
    quiet();
    sys_rst = 1;
    @(negedge clk);
    sys_rst = 0;
    @(negedge clk);
  endtask

  task automatic wr_burst(output bit ok, output bit fd);
    int n = 0;
    ok = 0; fd = 0;
    while (!sdram_wr_req && n < 20) begin
      @(negedge clk); n++;
    end
    if (sdram_wr_req) begin
      ok = 1;
      wr_ack = 1; @(negedge clk); wr_ack = 0;
      wr_end = 1; @(negedge clk); wr_end = 0;
      fd = wr_frame_done;
    end
  endtask

  task automatic rd_burst(output bit ok, output bit fd);
    int n = 0;
    ok = 0; fd = 0;
    while (!sdram_rd_req && n < 20) begin
      @(negedge clk); n++;
    end
    if (sdram_rd_req) begin
      ok = 1;
      rd_ack = 1; @(negedge clk); rd_ack = 0;
      rd_end = 1; @(negedge clk); rd_end = 0;
      fd = rd_frame_done;
    end
  endtask

  task automatic test_reset;
    quiet();
    sys_rst = 1;
    @(negedge clk);
    checks++;
    if (sdram_wr_req !== 1'b0) begin
      errors++; $display("FAIL reset_wr_req: got %b expected 0", sdram_wr_req);
    end
    checks++;
    if (sdram_rd_req !== 1'b0) begin
      errors++; $display("FAIL reset_rd_req: got %b expected 0", sdram_rd_req);
    end
    checks++;
    if (sdram_wr_addr !== 24'h0) begin
      errors++; $display("FAIL reset_wr_addr: got %h expected 000000", sdram_wr_addr);
    end
    checks++;
    if (sdram_rd_addr !== RD_BASE) begin
      errors++; $display("FAIL reset_rd_addr: got %h expected %h", sdram_rd_addr, RD_BASE);
    end
    checks++;
    if ({wr_frame_done, rd_frame_done} !== 2'b00) begin
      errors++; $display("FAIL reset_frame_done: got %b expected 00", {wr_frame_done, rd_frame_done});
    end
    sys_rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    do_reset();
    init_end = 1; wr_fifo_usedw = 512;
    @(negedge clk);
    checks++;
    if (sdram_wr_req !== 1'b1 || sdram_wr_addr !== 24'h0) begin
      errors++; $display("FAIL grant_wr: got req=%b addr=%h expected req=1 addr=000000", sdram_wr_req, sdram_wr_addr);
    end
    wr_ack = 1; @(negedge clk); wr_ack = 0;
    checks++;
    if (sdram_wr_req !== 1'b0) begin
      errors++; $display("FAIL ack_drop: got %b expected 0", sdram_wr_req);
    end
    wr_end = 1; @(negedge clk); wr_end = 0; wr_fifo_usedw = 0;
    checks++;
    if (sdram_wr_addr !== 24'd512) begin
      errors++; $display("FAIL wr_addr_step: got %h expected 000200", sdram_wr_addr);
    end
    @(negedge clk);
    checks++;
    if (sdram_wr_req !== 1'b0) begin
      errors++; $display("FAIL idle_no_grant: got %b expected 0", sdram_wr_req);
    end
    wr_end = 1; rd_end = 1; @(negedge clk); wr_end = 0; rd_end = 0;
    checks++;
    if (sdram_wr_addr !== 24'd512 || sdram_rd_addr !== RD_BASE) begin
      errors++; $display("FAIL idle_end_ignored: got wr=%h rd=%h expected wr=000200 rd=%h", sdram_wr_addr, sdram_rd_addr, RD_BASE);
    end
  endtask

  task automatic test_priority;
    do_reset();
    init_end = 1; wr_fifo_usedw = 600; read_valid = 1; rd_fifo_usedw = 100;
    @(negedge clk);
    checks++;
    if ({sdram_wr_req, sdram_rd_req} !== 2'b10) begin
      errors++; $display("FAIL prio_write_first: got wr/rd=%b expected 10", {sdram_wr_req, sdram_rd_req});
    end
    wr_ack = 1; @(negedge clk); wr_ack = 0;
    wr_end = 1; @(negedge clk); wr_end = 0;
    rd_fifo_usedw = 40;
    @(negedge clk);
    checks++;
    if ({sdram_wr_req, sdram_rd_req} !== 2'b01 || sdram_rd_addr !== RD_BASE) begin
      errors++; $display("FAIL prio_read_urgent: got wr/rd=%b addr=%h expected 01 addr=%h", {sdram_wr_req, sdram_rd_req}, sdram_rd_addr, RD_BASE);
    end
    rd_ack = 1; @(negedge clk); rd_ack = 0;
    rd_end = 1; @(negedge clk); rd_end = 0;
    quiet();
    checks++;
    if (sdram_rd_addr !== RD_BASE + 24'd512) begin
      errors++; $display("FAIL rd_addr_step: got %h expected %h", sdram_rd_addr, RD_BASE + 24'd512);
    end
  endtask

  task automatic test_write_frame;
    bit ok, fd, last_fd;
    int tmo = 0;
    int fd_cnt = 0;
    logic [23:0] addr_749 = '0;
    do_reset();
    init_end = 1; wr_fifo_usedw = 512;
    for (int i = 1; i <= 750; i++) begin
      wr_burst(ok, fd);
      if (!ok) tmo++;
      if (fd) fd_cnt++;
      if (i == 749) addr_749 = sdram_wr_addr;
      if (i == 750) begin
        last_fd = fd;
        wr_fifo_usedw = 0;
      end
    end
    checks++;
    if (tmo != 0) begin
      errors++; $display("FAIL frame_wr_timeout: got %0d expected 0", tmo);
    end
    checks++;
    if (addr_749 !== 24'h05DA00) begin
      errors++; $display("FAIL frame_wr_addr_749: got %h expected 05da00", addr_749);
    end
    checks++;
    if (fd_cnt != 1 || last_fd !== 1'b1) begin
      errors++; $display("FAIL wr_frame_done_count: got %0d last=%b expected 1 last=1", fd_cnt, last_fd);
    end
    checks++;
    if (sdram_wr_addr !== WR_WRAP) begin
      errors++; $display("FAIL wr_wrap_addr: got %h expected %h", sdram_wr_addr, WR_WRAP);
    end
    @(negedge clk);
    checks++;
    if (wr_frame_done !== 1'b0) begin
      errors++; $display("FAIL wr_frame_done_width: got %b expected 0", wr_frame_done);
    end
  endtask

`ifdef SDRAM_PINGPANG_EN
  task automatic test_pingpong;
    bit ok, fd;
    int tmo = 0;
    int fd_cnt = 0;
    logic [23:0] first_addr = '0;
    init_end = 1; read_valid = 1; rd_fifo_usedw = 100; wr_fifo_usedw = 0;
    for (int i = 1; i <= 750; i++) begin
      if (i == 1) begin
        @(negedge clk);
        first_addr = sdram_rd_addr;
      end
      rd_burst(ok, fd);
      if (!ok) tmo++;
      if (fd) fd_cnt++;
      if (i == 750) read_valid = 0;
    end
    checks++;
    if (first_addr !== 24'h400000) begin
      errors++; $display("FAIL pp_rd_start: got %h expected 400000", first_addr);
    end
    checks++;
    if (tmo != 0 || fd_cnt != 1) begin
      errors++; $display("FAIL pp_rd_frame: got tmo=%0d done=%0d expected 0 1", tmo, fd_cnt);
    end
    checks++;
    if (sdram_rd_addr !== 24'h000000 || sdram_wr_addr !== 24'h400000) begin
      errors++; $display("FAIL pp_rd_buf: got rd=%h wr=%h expected rd=000000 wr=400000", sdram_rd_addr, sdram_wr_addr);
    end
  endtask
`endif

  task automatic test_read_valid_drop;
    logic seen = 1'b0;
    do_reset();
    init_end = 1; read_valid = 1; rd_fifo_usedw = 100;
    @(negedge clk);
    checks++;
    if (sdram_rd_req !== 1'b1) begin
      errors++; $display("FAIL rv_grant: got %b expected 1", sdram_rd_req);
    end
    read_valid = 0;
    rd_ack = 1; @(negedge clk); rd_ack = 0;
    rd_end = 1; @(negedge clk); rd_end = 0;
    checks++;
    if (sdram_rd_addr !== RD_BASE + 24'd512) begin
      errors++; $display("FAIL rv_burst_done: got %h expected %h", sdram_rd_addr, RD_BASE + 24'd512);
    end
    repeat (5) begin
      @(negedge clk);
      seen = seen | sdram_rd_req;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rv_no_regrant: got %b expected 0", seen);
    end
  endtask

  task automatic test_reset_mid_burst;
    bit ok, fd;
    do_reset();
    init_end = 1; wr_fifo_usedw = 512;
    wr_burst(ok, fd);
    @(negedge clk);
    checks++;
    if (!ok || sdram_wr_req !== 1'b1 || sdram_wr_addr !== 24'd512) begin
      errors++; $display("FAIL mid_pre: got ok=%b req=%b addr=%h expected 1 1 000200", ok, sdram_wr_req, sdram_wr_addr);
    end
    #2 sys_rst = 1;
    #1;
    checks++;
    if (sdram_wr_req !== 1'b0 || sdram_wr_addr !== 24'h0) begin
      errors++; $display("FAIL async_reset: got req=%b addr=%h expected 0 000000", sdram_wr_req, sdram_wr_addr);
    end
    @(negedge clk);
    sys_rst = 0;
    @(negedge clk);
    checks++;
    if (sdram_wr_req !== 1'b1 || sdram_wr_addr !== 24'h0) begin
      errors++; $display("FAIL post_reset_grant: got req=%b addr=%h expected 1 000000", sdram_wr_req, sdram_wr_addr);
    end
    quiet();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    sys_rst = 1;
    test_reset();
    test_single_write();
    test_priority();
    test_write_frame();
`ifdef SDRAM_PINGPANG_EN
    test_pingpong();
`endif
    test_read_valid_drop();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
